// File: rtl/store_buffer.sv
// store_buffer: write-posting FIFO between the store-formatting stage and a
// single-ported data memory. Stores drain whenever no load owns the port.
// A load that matches a pending store's word waits until that word is written.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_bwe,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  output logic        mem_en,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_din,
  output logic        empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_LOAD,
    GNT_STORE
  } grant_t;

  logic [29:0]   waddr_q [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [3:0]    bwe_q   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic   full;
  logic   enq;
  logic   hit;
  logic   drain;
  grant_t grant;

  // Byte-offset bits are ignored; the memory is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign full     = (count == CW'(DEPTH));
  assign st_ready = !full;
  assign empty    = (count == '0);
  assign enq      = st_valid && st_ready && (st_bwe != 4'b0000);

  // Load/store word hazard against every live entry and the store enqueueing now.
  always_comb begin
    logic [PW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (waddr_q[idx] == ld_addr[31:2]))
        hit = 1'b1;
    end
    if (enq && (st_addr[31:2] == ld_addr[31:2]))
      hit = 1'b1;
    if (!ld_valid)
      hit = 1'b0;
  end

  // Memory port arbitration: forced drain when full, then loads, then drains.
  always_comb begin
    grant = GNT_IDLE;
    if (full && (count != '0))
      grant = GNT_STORE;
    else if (ld_valid && !hit)
      grant = GNT_LOAD;
    else if (count != '0)
      grant = GNT_STORE;
  end

  // Drive the memory port from the granted requester.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_we   = '0;
    mem_din  = '0;
    ld_ready = 1'b0;
    drain    = 1'b0;
    case (grant)
      GNT_LOAD: begin
        ld_ready = 1'b1;
        mem_en   = 1'b1;
        mem_addr = ld_addr[31:2];
      end
      GNT_STORE: begin
        drain    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = waddr_q[rd_ptr];
        mem_we   = bwe_q[rd_ptr];
        mem_din  = data_q[rd_ptr];
      end
      default: ;
    endcase
  end

  // Entry payload; contents of unused slots are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      waddr_q[wr_ptr] <= st_addr[31:2];
      data_q[wr_ptr]  <= st_data;
      bwe_q[wr_ptr]   <= st_bwe;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (drain)
        rd_ptr <= rd_ptr + 1'b1;
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a write scoreboard. Every accepted
// non-zero-bwe store is queued as an expected memory write; every observed
// memory write is popped and compared in order.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_bwe;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic        empty;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  wr_t sb_q[$];

  store_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_bwe   (st_bwe),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_ready (ld_ready),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare writes first, then record this cycle's accepted store.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (mem_en && (mem_we != 4'b0000)) begin
        if (sb_q.size() == 0)
          check("stray_write", {mem_addr, mem_din, mem_we}, '0);
        else
          check("drain_order", {mem_addr, mem_din, mem_we}, sb_q.pop_front());
      end
      if (st_valid && st_ready && (st_bwe != 4'b0000))
        sb_q.push_back({st_addr[31:2], st_data, st_bwe});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_bwe   = b;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a);
    ld_valid = v;
    ld_addr  = a;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20 && !empty; i++)
      cyc();
    check(tag, empty, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_store(1'b0, '0, '0, '0);
    set_load(1'b0, '0);
    #1;
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_empty",    empty,    1'b1);
    check("rst_mem_en",   mem_en,   1'b0);
    check("rst_mem_we",   mem_we,   4'h0);
    check("rst_ld_ready", ld_ready, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single store, then idle.
    set_store(1'b1, 32'h104, 32'hAABBCCDD, 4'hF);
    #1 check("t1_st_ready", st_ready, 1'b1);
    cyc();
    set_store(1'b0, '0, '0, '0);
    #1;
    check("t1_mem_en",   mem_en,   1'b1);
    check("t1_mem_addr", mem_addr, 30'h41);
    check("t1_mem_we",   mem_we,   4'hF);
    check("t1_mem_din",  mem_din,  32'hAABBCCDD);
    cyc();
    check("t1_empty", empty, 1'b1);

    // Load priority over a buffered store.
    set_store(1'b1, 32'h200, 32'h11223344, 4'h3);
    set_load(1'b1, 32'h300);
    cyc();
    set_store(1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_ld_ready", ld_ready, 1'b1);
      check("t2_mem_we",   mem_we,   4'h0);
      check("t2_mem_addr", mem_addr, 30'hC0);
      cyc();
    end
    check("t2_still_buffered", empty, 1'b0);
    set_load(1'b0, '0);
    #1 check("t2_drain_addr", mem_addr, 30'h80);
    cyc();
    check("t2_empty", empty, 1'b1);

    // Hazard: load to 0x10 waits for all three stores to drain in order.
    set_load(1'b1, 32'h300);
    set_store(1'b1, 32'h10, 32'h0A0A0A0A, 4'hF);
    cyc();
    set_store(1'b1, 32'h20, 32'h0B0B0B0B, 4'hF);
    cyc();
    set_store(1'b1, 32'h10, 32'h0C0C0C0C, 4'hF);
    cyc();
    set_store(1'b0, '0, '0, '0);
    set_load(1'b1, 32'h10);
    for (int i = 0; i < 3; i++) begin
      logic [29:0] exp_a;
      exp_a = (i == 1) ? 30'h8 : 30'h4;
      #1;
      check("t3_ld_blocked", ld_ready, 1'b0);
      check("t3_drain_addr", mem_addr, exp_a);
      cyc();
    end
    #1;
    check("t3_ld_ready", ld_ready, 1'b1);
    check("t3_ld_we",    mem_we,   4'h0);
    cyc();
    set_load(1'b0, '0);
    check("t3_empty", empty, 1'b1);

    // Full buffer with a non-hitting load every cycle: forced drain.
    set_load(1'b1, 32'h300);
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF);
      #1;
      check("t4_st_ready_fill", st_ready, 1'b1);
      check("t4_ld_ready_fill", ld_ready, 1'b1);
      cyc();
    end
    set_store(1'b0, '0, '0, '0);
    #1;
    check("t4_full_st_ready", st_ready, 1'b0);
    check("t4_forced_ld",     ld_ready, 1'b0);
    check("t4_forced_addr",   mem_addr, 30'h100);
    cyc();
    check("t4_st_ready_back", st_ready, 1'b1);
    check("t4_ld_ready_back", ld_ready, 1'b1);
    set_load(1'b0, '0);
    wait_empty("t4_drained");

    // Zero-bwe store is handshaken but never written.
    set_store(1'b1, 32'h500, 32'hDEADBEEF, 4'h0);
    #1 check("t5_zero_ready", st_ready, 1'b1);
    cyc();
    set_store(1'b0, '0, '0, '0);
    #1;
    check("t5_zero_no_mem", mem_en, 1'b0);
    check("t5_zero_empty",  empty,  1'b1);

    // Same-cycle store/load to the same word.
    set_store(1'b1, 32'h40, 32'h55667788, 4'hF);
    set_load(1'b1, 32'h40);
    #1;
    check("t5_same_ld", ld_ready, 1'b0);
    check("t5_same_en", mem_en,   1'b0);
    cyc();
    set_store(1'b0, '0, '0, '0);
    #1;
    check("t5_wait_ld",   ld_ready, 1'b0);
    check("t5_wait_addr", mem_addr, 30'h10);
    cyc();
    check("t5_ld_go", ld_ready, 1'b1);
    cyc();
    set_load(1'b0, '0);

    // Reset mid-drain with three stores buffered.
    set_load(1'b1, 32'h300);
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h600 + 32'(4 * i), 32'hE000_0000 + 32'(i), 4'hF);
      cyc();
    end
    set_store(1'b0, '0, '0, '0);
    set_load(1'b0, '0);
    #1 check("t6_draining", mem_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty",    empty,    1'b1);
    check("t6_rst_mem_en",   mem_en,   1'b0);
    check("t6_rst_st_ready", st_ready, 1'b1);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t6_no_write", mem_en, 1'b0);
    end
    check("sb_leftover", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-posting buffer between the store-formatting stage and the single-ported data memory. Accepted stores (word address, shifted data, byte enables) go into a small FIFO. Stores drain to memory in cycles when no load owns the port, so a store never stalls the pipeline unless the buffer is full. Loads that hit a pending store's word are held until that word has been written, which keeps memory ordering intact.

## Interface

Parameters
- DEPTH, 4: entry count; power of two, >= 2.

Ports (one clock; reset is asynchronous and active-low)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store offered this cycle
- st_addr  in  32  byte address; only [31:2] is used
- st_data  in  32  lane-aligned store data
- st_bwe  in  4  byte write enables; 4'b0000 means no-op store
- st_ready  out  1  store accepted when st_valid && st_ready
- ld_valid  in  1  load wants the memory port this cycle
- ld_addr  in  32  byte address; only [31:2] is used
- ld_ready  out  1  load owns the memory port this cycle
- mem_en  out  1  memory access this cycle
- mem_addr  out  30  word address
- mem_we  out  4  byte write enables; 0 for a load
- mem_din  out  32  write data
- empty  out  1  no buffered entries (fence/flush condition)

## Operation

- Storage: FIFO of DEPTH entries {waddr[29:0], data[31:0], bwe[3:0]} plus wr_ptr, rd_ptr and count[log2(DEPTH):0].
- Enqueue: st_valid && st_ready && st_bwe!=0 writes the tail entry and advances wr_ptr modulo DEPTH.
  - A zero-bwe store is handshaken (st_ready follows the normal rule) but is never enqueued.
- st_ready = (count != DEPTH). There is no same-cycle pass-through when full.
- Hazard: hit = ld_valid && (ld_addr[31:2] matches waddr of any valid entry, or matches st_addr[31:2] of a same-cycle enqueueing store).
- Port arbitration, evaluated combinationally each cycle, in priority order:
  1. count==DEPTH and count!=0: the head store drains; ld_ready=0.
  2. ld_valid && !hit: the load wins; ld_ready=1, mem_en=1, mem_addr=ld_addr[31:2], mem_we=0.
  3. count!=0: the head store drains; mem_en=1, mem_addr=head.waddr, mem_we=head.bwe, mem_din=head.data.
     - Dequeue at the edge: rd_ptr advances modulo DEPTH and count decrements.
     - ld_ready=0 whenever a load is valid.
  4. Otherwise idle: mem_en=0, mem_we=0, ld_ready=0.
- Stores drain strictly in FIFO order, one per cycle. A drain and an enqueue in the same cycle leave count unchanged.
- empty = (count==0).
- Reset (asynchronous, any time including mid-drain): pointers and count go to 0 and all buffered stores are discarded.
  - Outputs after reset: st_ready=1, empty=1, mem_en=0, mem_we=0, ld_ready=0.
  - mem_addr and mem_din are don't-care while mem_en=0; drive them to 0.

## Timing

- Enqueue-to-write latency: a store accepted at edge N is first eligible to drive the memory port in cycle N+1. Memory commits it at edge N+1.
- Load latency: zero added cycles when there is no hit and the buffer is not full. ld_ready is combinational from ld_valid, ld_addr and buffer state.
- A hitting load waits until every matching entry has drained. ld_ready rises in the cycle after the last matching entry's write edge.
- Full buffer: st_ready=0 for exactly the cycles where count==DEPTH. A forced drain guarantees it falls back within 1 cycle.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.
- No combinational path from mem_* inputs; the memory is write-only from this block's view.

## Test plan

- Single store, then idle: st_addr=0x104, st_data=0xAABBCCDD, bwe=4'b1111 at edge 0.
  - Expect mem_en=1, mem_addr=0x41, mem_we=4'hF, mem_din=0xAABBCCDD in cycle 1.
  - Expect empty=1 after edge 1.
- Load priority: buffer holds store to 0x200; ld_valid to 0x300 every cycle for 3 cycles.
  - Expect ld_ready=1 and mem_we=0 for all 3 cycles, and the store stays buffered.
  - The store drains in the first cycle with ld_valid=0.
- Hazard: buffer holds stores to 0x10, 0x20, 0x10; load to 0x10.
  - Expect ld_ready=0 while the three stores drain in order 0x4, 0x8, 0x4.
  - Expect ld_ready=1 in the next cycle.
- Full and starvation: DEPTH=4; enqueue 4 stores while ld_valid=1 to a non-hitting address.
  - Expect st_ready=0, then a forced drain (ld_ready=0) for one cycle.
  - Expect st_ready=1 in the following cycle.
- Zero-bwe store and same-cycle hit: st_bwe=0 is accepted but mem_en never shows it.
  - A store to 0x40 and a load to 0x40 in the same cycle: expect ld_ready=0 that cycle.
- Reset mid-drain: assert rst_n=0 with 3 stores buffered.
  - Expect immediate empty=1, mem_en=0, st_ready=1, and no further memory writes after release.
